// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, flag bit positions, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_pkg;

    // Opcode map; 13..15 decode as no-operation.
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOT  = 4'd4;
    localparam logic [3:0] OP_INC  = 4'd5;
    localparam logic [3:0] OP_DEC  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_PASS = 4'd9;
    localparam logic [3:0] OP_SETC = 4'd10;
    localparam logic [3:0] OP_CLRC = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    // Bit positions inside the packed flag register.
    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;

    // Top-level handshake FSM: IDLE accepts requests, MUL waits on the multiplier.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier, W x W -> 2W, one partial product per cycle.
// Latency: W cycles from start; done pulses during the W-th busy cycle with product valid.
// Backpressure: none; the caller must only pulse start while no multiply is in flight.
//
// Ports: clk, rst (sync, active-high), start (load operands), a (multiplicand),
//        b (multiplier), done (final step this cycle), product (accumulator after this step).
// Built only when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]   mcand;
    // Upper half accumulates partial sums; lower half starts as the multiplier
    // and is shifted out one bit per step, so acc[0] is always the current bit.
    logic [2*W-1:0] acc;
    logic [CW-1:0]  count;
    // One extra bit keeps the carry of the upper-half add before the shift.
    logic [W:0]     partial;

    always_comb begin
        partial = {1'b0, acc[2*W-1:W]};
        if (acc[0]) begin
            partial = {1'b0, acc[2*W-1:W]} + {1'b0, mcand};
        end
    end

    // Next accumulator value: add, then shift the whole W+1+W-1 word right by one.
    assign product = {partial, acc[W-1:1]};
    // The step taken while count==1 is the last one; product is final right now.
    assign done    = (count == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            acc   <= '0;
            count <= '0;
        end else if (start) begin
            mcand <= a;
            acc   <= {{W{1'b0}}, b};
            count <= CW'(W);
        end else if (count != '0) begin
            acc   <= product;
            count <= count - CW'(1);
        end
    end

endmodule
`endif

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle arithmetic/logic/shift ops plus optional iterative MUL.
// Latency: 1 cycle for single-cycle ops, W+1 cycles for MUL (accept to valid_out).
// Backpressure: in_ready drops for the W busy cycles of a MUL; requests then are ignored.
//
// Ports: clk, rst (sync, active-high); valid_in/in_ready request handshake; op, in1, in2
//        operands; valid_out one-cycle result strobe; result/result_hi low/high words;
//        carry/zero/neg registered flags.
// Build option: define ALU_MUL_EN to build MUL; otherwise op 12 is a NOP,
//        result_hi is 0 and in_ready is constantly 1.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W   = 16,
    parameter int SHW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    output logic         valid_out,
    output logic [W-1:0] result,
    output logic [W-1:0] result_hi,
    output logic         carry,
    output logic         zero,
    output logic         neg
);

    logic [2:0]     flags;
    logic [SHW-1:0] shamt;

    // Single-cycle datapath
    logic [W:0]     arith;
    logic [W:0]     shl_ext;
    logic [W:0]     shr_ext;
    logic [W-1:0]   sc_res;
    logic           sc_c;
    logic           sc_upd_c;
    logic           sc_upd_zn;
    logic           op_is_mul;
    logic           take_single;

    assign shamt = in2[SHW-1:0];

    always_comb begin
        arith     = '0;
        // One guard bit beyond the word catches the last bit shifted out.
        shl_ext   = {1'b0, in1} << shamt;
        shr_ext   = {in1, 1'b0} >> shamt;
        sc_res    = '0;
        sc_c      = flags[FLG_C];
        sc_upd_c  = 1'b0;
        sc_upd_zn = 1'b0;
        case (op)
            OP_ADD: begin
                arith     = {1'b0, in1} + {1'b0, in2};
                sc_res    = arith[W-1:0];
                sc_c      = arith[W];
                sc_upd_c  = 1'b1;
                sc_upd_zn = 1'b1;
            end
            OP_SUB: begin
                // in1 + ~in2 + 1: bit W is the inverted borrow.
                arith     = {1'b0, in1} + {1'b0, ~in2} + (W+1)'(1);
                sc_res    = arith[W-1:0];
                sc_c      = arith[W];
                sc_upd_c  = 1'b1;
                sc_upd_zn = 1'b1;
            end
            OP_AND: begin
                sc_res    = in1 & in2;
                sc_upd_zn = 1'b1;
            end
            OP_OR: begin
                sc_res    = in1 | in2;
                sc_upd_zn = 1'b1;
            end
            OP_NOT: begin
                sc_res    = ~in1;
                sc_upd_zn = 1'b1;
            end
            OP_INC: begin
                arith     = {1'b0, in1} + (W+1)'(1);
                sc_res    = arith[W-1:0];
                sc_c      = arith[W];
                sc_upd_c  = 1'b1;
                sc_upd_zn = 1'b1;
            end
            OP_DEC: begin
                // Adding all-ones is subtracting one; bit W is again the inverted borrow.
                arith     = {1'b0, in1} + {1'b0, {W{1'b1}}};
                sc_res    = arith[W-1:0];
                sc_c      = arith[W];
                sc_upd_c  = 1'b1;
                sc_upd_zn = 1'b1;
            end
            OP_SHL: begin
                sc_res    = shl_ext[W-1:0];
                sc_c      = shl_ext[W];
                sc_upd_c  = (shamt != '0);
                sc_upd_zn = 1'b1;
            end
            OP_SHR: begin
                sc_res    = shr_ext[W:1];
                sc_c      = shr_ext[0];
                sc_upd_c  = (shamt != '0);
                sc_upd_zn = 1'b1;
            end
            OP_PASS: begin
                sc_res    = in2;
                sc_upd_zn = 1'b1;
            end
            OP_SETC: begin
                sc_c      = 1'b1;
                sc_upd_c  = 1'b1;
            end
            OP_CLRC: begin
                sc_c      = 1'b0;
                sc_upd_c  = 1'b1;
            end
            default: begin
                // NOP (and MUL, which never takes this path when it is built).
            end
        endcase
    end

`ifdef ALU_MUL_EN
    alu_state_t     state;
    logic           mul_start;
    logic           mul_done;
    logic [2*W-1:0] mul_product;

    assign op_is_mul = (op == OP_MUL);
    // in_ready is only high in IDLE, so accept implies the FSM is idle.
    assign mul_start = valid_in && in_ready && op_is_mul;

    alu_mul_seq #(
        .W (W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (in1),
        .b       (in2),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign op_is_mul = 1'b0;
    assign in_ready  = 1'b1;
    assign result_hi = '0;
`endif

    assign take_single = valid_in && in_ready && !op_is_mul;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            result    <= '0;
            flags     <= '0;
`ifdef ALU_MUL_EN
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            result_hi <= '0;
`endif
        end else begin
            valid_out <= 1'b0;

            if (take_single) begin
                valid_out <= 1'b1;
                result    <= sc_res;
`ifdef ALU_MUL_EN
                result_hi <= '0;
`endif
                if (sc_upd_c) begin
                    flags[FLG_C] <= sc_c;
                end
                if (sc_upd_zn) begin
                    flags[FLG_Z] <= (sc_res == '0);
                    flags[FLG_N] <= sc_res[W-1];
                end
            end

`ifdef ALU_MUL_EN
            case (state)
                ST_IDLE: begin
                    if (mul_start) begin
                        state    <= ST_MUL;
                        in_ready <= 1'b0;
                    end
                end
                ST_MUL: begin
                    // Carry is left untouched by MUL; Z/N look at the full product.
                    if (mul_done) begin
                        state        <= ST_IDLE;
                        in_ready     <= 1'b1;
                        valid_out    <= 1'b1;
                        result       <= mul_product[W-1:0];
                        result_hi    <= mul_product[2*W-1:W];
                        flags[FLG_Z] <= (mul_product == '0);
                        flags[FLG_N] <= mul_product[2*W-1];
                    end
                end
            endcase
`endif
        end
    end

    assign carry = flags[FLG_C];
    assign zero  = flags[FLG_Z];
    assign neg   = flags[FLG_N];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a cycle-level reference model and literal spot checks.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int          W   = 16;
    localparam int unsigned MAX = 32'h0000_FFFF;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_in;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic         valid_out;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         carry;
    logic         zero;
    logic         neg;

    always #5 clk = ~clk;

    alu_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .in_ready  (in_ready),
        .op        (op),
        .in1       (in1),
        .in2       (in2),
        .valid_out (valid_out),
        .result    (result),
        .result_hi (result_hi),
        .carry     (carry),
        .zero      (zero),
        .neg       (neg)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Reference model: expected outputs for the cycle following each rising edge.
    bit              live = 1'b0;
    logic            e_vo, e_rdy, e_c, e_z, e_n;
    logic [W-1:0]    e_res, e_hi;
    int              busy;
    longint unsigned pend;

    always @(posedge clk) begin : model
        int unsigned a, b, r, sh;
        bit cv, uc, uzn, mstart;
        if (rst) begin
            live = 1'b1;
            e_vo = 0; e_rdy = 1; e_c = 0; e_z = 0; e_n = 0;
            e_res = '0; e_hi = '0; busy = 0; pend = 0;
        end else if (live) begin
            e_vo = 0;
            if (busy > 0) begin
                busy--;
                if (busy == 0) begin
                    e_vo  = 1; e_rdy = 1;
                    e_res = pend[W-1:0];
                    e_hi  = pend[2*W-1:W];
                    e_z   = (pend == 0);
                    e_n   = pend[2*W-1];
                end
            end else if (valid_in) begin
                a = in1; b = in2; r = 0; cv = e_c; uc = 0; uzn = 0; mstart = 0;
                sh = b % W;
                case (op)
                    OP_ADD:  begin r = (a + b) & MAX; cv = (a + b) > MAX; uc = 1; uzn = 1; end
                    OP_SUB:  begin r = (a - b) & MAX; cv = (a >= b); uc = 1; uzn = 1; end
                    OP_AND:  begin r = a & b; uzn = 1; end
                    OP_OR:   begin r = a | b; uzn = 1; end
                    OP_NOT:  begin r = (~a) & MAX; uzn = 1; end
                    OP_INC:  begin r = (a + 1) & MAX; cv = (a == MAX); uc = 1; uzn = 1; end
                    OP_DEC:  begin r = (a - 1) & MAX; cv = (a != 0); uc = 1; uzn = 1; end
                    OP_SHL:  begin
                        r = (a << sh) & MAX; uzn = 1;
                        if (sh != 0) begin cv = ((a >> (W - sh)) & 1) != 0; uc = 1; end
                    end
                    OP_SHR:  begin
                        r = a >> sh; uzn = 1;
                        if (sh != 0) begin cv = ((a >> (sh - 1)) & 1) != 0; uc = 1; end
                    end
                    OP_PASS: begin r = b; uzn = 1; end
                    OP_SETC: begin cv = 1; uc = 1; end
                    OP_CLRC: begin cv = 0; uc = 1; end
`ifdef ALU_MUL_EN
                    OP_MUL:  begin
                        pend = longint'(a) * longint'(b);
                        busy = W; e_rdy = 0; mstart = 1;
                    end
`endif
                    default: ;
                endcase
                if (!mstart) begin
                    e_vo = 1; e_res = r[W-1:0]; e_hi = '0;
                    if (uc) e_c = cv;
                    if (uzn) begin e_z = (r == 0); e_n = ((r >> (W - 1)) & 1) != 0; end
                end
            end
        end
    end

    // Every cycle after the first reset edge the DUT must match the model.
    always @(negedge clk) begin
        if (live) begin
            chk("m_valid_out", valid_out, e_vo);
            chk("m_in_ready",  in_ready,  e_rdy);
            chk("m_result",    result,    e_res);
            chk("m_result_hi", result_hi, e_hi);
            chk("m_carry",     carry,     e_c);
            chk("m_zero",      zero,      e_z);
            chk("m_neg",       neg,       e_n);
        end
    end

    // Called at a falling edge; holds the request until the model says it is taken,
    // returns at the falling edge of the following cycle.
    task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        op = o; in1 = a; in2 = b; valid_in = 1'b1;
        while (!e_rdy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            total_cnt++;
            $display("FAIL issue_timeout: waited %0d cycles, required under 100", guard);
        end
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    logic [3:0]   burst_op [8] = '{OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_AND, OP_INC, OP_DEC, OP_PASS};
    logic [W-1:0] burst_a  [8] = '{16'h1234, 16'h0005, 16'hC003, 16'h8001, 16'hF0F0, 16'h7FFF, 16'h8000, 16'h0000};
    logic [W-1:0] burst_b  [8] = '{16'h4321, 16'h0005, 16'h0002, 16'h0004, 16'h0FF0, 16'h0000, 16'h0000, 16'h0000};

    initial begin
        int n;
        rst = 1'b1; valid_in = 1'b0; op = '0; in1 = '0; in2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_valid_out", valid_out, 0);
        chk("rst_result",    result,    0);
        chk("rst_result_hi", result_hi, 0);
        chk("rst_carry",     carry,     0);
        chk("rst_zero",      zero,      0);
        chk("rst_neg",       neg,       0);
        rst = 1'b0;
        @(negedge clk);

        issue(OP_ADD, 16'hFFFF, 16'h0001);
        chk("add_vo", valid_out, 1); chk("add_res", result, 16'h0000);
        chk("add_c", carry, 1); chk("add_z", zero, 1); chk("add_n", neg, 0);

        issue(OP_SUB, 16'd20, 16'd30);
        chk("sub_res", result, 16'hFFF6); chk("sub_n", neg, 1); chk("sub_c", carry, 0);

        issue(OP_SHL, 16'h8001, 16'h0001);
        chk("shl_res", result, 16'h0002); chk("shl_c", carry, 1);

        issue(OP_SHR, 16'h0003, 16'h0000);
        chk("shr0_res", result, 16'h0003); chk("shr0_c_kept1", carry, 1);

        issue(OP_CLRC, 16'h1111, 16'h2222);
        chk("clrc_res", result, 16'h0000); chk("clrc_c", carry, 0); chk("clrc_z_kept", zero, 0);

        issue(OP_SHR, 16'h0003, 16'h0000);
        chk("shr0_c_kept0", carry, 0);

        issue(OP_SETC, 16'h0000, 16'h0000);
        issue(OP_AND, 16'h0005, 16'h0003);
        chk("and_res", result, 16'h0001); chk("and_c", carry, 1);

        issue(OP_DEC, 16'h0000, 16'h0000);
        chk("dec_res", result, 16'hFFFF); chk("dec_c", carry, 0); chk("dec_n", neg, 1);

        issue(OP_INC, 16'hFFFF, 16'h0000);
        chk("inc_res", result, 16'h0000); chk("inc_c", carry, 1); chk("inc_z", zero, 1);

        issue(OP_NOT, 16'h00F0, 16'h0000);
        chk("not_res", result, 16'hFF0F); chk("not_n", neg, 1); chk("not_c", carry, 1);

        issue(OP_OR, 16'h1200, 16'h0034);
        chk("or_res", result, 16'h1234);

        // Only in2[3:0] is the shift amount: 0x11 shifts by 1.
        issue(OP_SHL, 16'h0001, 16'h0011);
        chk("shl_mask_res", result, 16'h0002); chk("shl_mask_c", carry, 0);

        issue(OP_SHR, 16'h8000, 16'h000F);
        chk("shr15_res", result, 16'h0001); chk("shr15_c", carry, 0);

        issue(OP_PASS, 16'h0000, 16'h8000);
        chk("pass_res", result, 16'h8000); chk("pass_n", neg, 1);

        issue(4'd13, 16'h0007, 16'h0007);
        chk("nop_vo", valid_out, 1); chk("nop_res", result, 16'h0000);
        chk("nop_c", carry, 0); chk("nop_z", zero, 0); chk("nop_n", neg, 1);

`ifdef ALU_MUL_EN
        issue(OP_MUL, 16'h00FF, 16'h0101);
        chk("mul_busy_rdy", in_ready, 0);
        n = 1;
        while (!valid_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("mul_latency", n, 17);
        chk("mul1_res", result, 16'hFFFF); chk("mul1_hi", result_hi, 16'h0000);
        chk("mul1_z", zero, 0); chk("mul1_n", neg, 0);

        // ADD held during the busy window must be taken exactly once.
        issue(OP_MUL, 16'hFFFF, 16'hFFFF);
        op = OP_ADD; in1 = 16'h0002; in2 = 16'h0003; valid_in = 1'b1;
        n = 0;
        while (!valid_out && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("mul2_res", result, 16'h0001); chk("mul2_hi", result_hi, 16'hFFFE);
        chk("mul2_n", neg, 1); chk("mul2_rdy", in_ready, 1);
        @(negedge clk);
        valid_in = 1'b0;
        chk("held_add_vo", valid_out, 1); chk("held_add_res", result, 16'h0005);
        chk("held_add_hi", result_hi, 16'h0000);
        @(negedge clk);
        chk("held_add_once", valid_out, 0);

        issue(OP_MUL, 16'h0003, 16'h0004);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rdy", in_ready, 1); chk("abort_vo", valid_out, 0);
        rst = 1'b0;
        n = 0;
        repeat (25) begin
            @(negedge clk);
            if (valid_out) n++;
        end
        chk("abort_no_pulse", n, 0);
`else
        issue(OP_MUL, 16'h0005, 16'h0006);
        chk("mul_off_vo", valid_out, 1); chk("mul_off_res", result, 16'h0000);
        chk("mul_off_hi", result_hi, 16'h0000); chk("mul_off_rdy", in_ready, 1);
        chk("mul_off_c", carry, 0); chk("mul_off_z", zero, 0); chk("mul_off_n", neg, 1);
`endif

        // Back-to-back burst: one request every cycle, model checks each result.
        for (int i = 0; i < 8; i++) begin
            issue(burst_op[i], burst_a[i], burst_b[i]);
        end
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
